// File: rtl/lcd_timing_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lcd_timing_pkg
// Shared LCD timing constants, panel presets and the pixel coordinate type.
// Revision : 1.0
// ============================================================================

package lcd_timing_pkg;

  localparam int LCD_H_ACTIVE_DEFAULT = 800;
  localparam int LCD_V_ACTIVE_DEFAULT = 480;
  localparam int LCD_CW_DEFAULT       = 11;

  localparam int PANEL_800X480_H = 800;
  localparam int PANEL_800X480_V = 480;
  localparam int PANEL_800X600_H = 800;
  localparam int PANEL_800X600_V = 600;

  typedef struct packed {
    logic [LCD_CW_DEFAULT-1:0] x;
    logic [LCD_CW_DEFAULT-1:0] y;
  } lcd_coord_t;

endpackage

`default_nettype wire

// File: rtl/lcd_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : lcd_edge_det
// Registered rise/fall detector for a single synchronous level signal.
// Revision : 1.0
// ============================================================================

module lcd_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic r_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d <= 1'b0;
    end else begin
      r_d <= d;
    end
  end

  assign rise = d & ~r_d;
  assign fall = ~d & r_d;

endmodule

`default_nettype wire

// File: rtl/lcd_de_pixel_tracker.sv
`default_nettype none
// ============================================================================
// Module   : lcd_de_pixel_tracker
// Recovers active-pixel (x, y) from DE with vsync realignment and an overlay
// window hit flag. Define LCD_TRACK_ERR_EN to build the sticky length checkers.
// Revision : 1.0
// ============================================================================

module lcd_de_pixel_tracker
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = LCD_V_ACTIVE_DEFAULT,
  parameter int CW       = LCD_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          den,
  input  logic          vs_n,
  input  logic [CW-1:0] win_x0,
  input  logic [CW-1:0] win_x1,
  input  logic [CW-1:0] win_y0,
  input  logic [CW-1:0] win_y1,
  input  logic          err_clr,
  output logic          pixel_valid,
  output logic [CW-1:0] count_x,
  output logic [CW-1:0] count_y,
  output logic          in_window,
  output logic          line_end,
  output logic          frame_end,
  output logic          err_len,
  output logic          err_lines
);

  localparam logic [CW-1:0] c_h_active = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_v_active = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_v_last   = CW'(V_ACTIVE - 1);

  logic          w_den_rise, w_den_fall, w_vs_rise, w_vs_fall;
  logic          w_unused_edges;
  logic [CW-1:0] r_x, r_y;
  logic [CW-1:0] w_nx, w_ny, w_px, w_py;
  logic          w_line_end, w_frame_end, w_len_bad, w_hit;

  lcd_edge_det u_den_edge (
    .clk   (clk),
    .reset (reset),
    .d     (den),
    .rise  (w_den_rise),
    .fall  (w_den_fall)
  );

  lcd_edge_det u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .d     (vs_n),
    .rise  (w_vs_rise),
    .fall  (w_vs_fall)
  );

  assign w_unused_edges = w_den_rise ^ w_vs_rise;

  // r_x is the pixel count of the current line, so it reaches H_ACTIVE
  // after a full line; a further DE-high pixel is the wrap boundary.
  always_comb begin
    w_px        = r_x;
    w_py        = r_y;
    w_nx        = r_x;
    w_ny        = r_y;
    w_line_end  = 1'b0;
    w_frame_end = 1'b0;
    w_len_bad   = 1'b0;
    if (w_vs_fall) begin
      w_px = '0;
      w_py = '0;
      w_nx = den ? CW'(1) : '0;
      w_ny = '0;
    end else if (w_den_fall || (den && (r_x == c_h_active))) begin
      w_line_end = 1'b1;
      w_len_bad  = (r_x != c_h_active);
      if (r_y == c_v_last) begin
        w_ny        = '0;
        w_frame_end = 1'b1;
      end else begin
        w_ny = r_y + 1'b1;
      end
      w_px = '0;
      w_py = w_ny;
      w_nx = den ? CW'(1) : '0;
    end else if (den) begin
      w_nx = r_x + 1'b1;
    end
  end

  assign w_hit = (w_px >= win_x0) && (w_px <= win_x1) &&
                 (w_py >= win_y0) && (w_py <= win_y1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x         <= '0;
      r_y         <= '0;
      pixel_valid <= 1'b0;
      count_x     <= '0;
      count_y     <= '0;
      in_window   <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      r_x         <= w_nx;
      r_y         <= w_ny;
      pixel_valid <= den;
      if (den) begin
        count_x <= w_px;
        count_y <= w_py;
      end
      in_window   <= den && w_hit;
      line_end    <= w_line_end;
      frame_end   <= w_frame_end;
    end
  end

`ifdef LCD_TRACK_ERR_EN
  logic [CW-1:0] r_lines;
  logic          r_vs_seen;
  logic          r_err_len;
  logic          r_err_lines;

  // The line counter saturates so an overlong frame can never alias to V_ACTIVE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lines     <= '0;
      r_vs_seen   <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_lines <= 1'b0;
    end else begin
      if (w_vs_fall) begin
        r_lines   <= '0;
        r_vs_seen <= 1'b1;
      end else if (w_line_end && (r_lines != '1)) begin
        r_lines <= r_lines + 1'b1;
      end
      if (w_line_end && w_len_bad) begin
        r_err_len <= 1'b1;
      end else if (err_clr) begin
        r_err_len <= 1'b0;
      end
      if (w_vs_fall && r_vs_seen && (r_lines != c_v_active)) begin
        r_err_lines <= 1'b1;
      end else if (err_clr) begin
        r_err_lines <= 1'b0;
      end
    end
  end

  assign err_len   = r_err_len;
  assign err_lines = r_err_lines;
`else
  logic w_unused_err;

  assign w_unused_err = err_clr ^ w_len_bad ^ (c_v_active == '0);
  assign err_len      = 1'b0;
  assign err_lines    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/lcd_de_pixel_tracker.md
Name: lcd_de_pixel_tracker

Overview:
Recovers the active-pixel coordinates (x, y) of a DE-mode LCD stream from the data-enable strobe. It also gives an optional vsync alignment and a runtime overlay-window hit flag for image blending.
- Fully synchronous to the LCD pixel clock. No derived clocks, and no counter is clocked from a data signal.
- Sits between the LCD timing generator and the blending/overlay datapath.

Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- CW, 11, counter width; must satisfy 2^CW > max(H_ACTIVE, V_ACTIVE).

Ports:
- clk  in  1  LCD pixel clock; all logic on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- den  in  1  data enable from the timing generator; 1 = active pixel this cycle.
- vs_n  in  1  vertical sync, active-low; its falling edge realigns the frame.
- win_x0, win_x1  in  CW  overlay window x bounds, inclusive.
- win_y0, win_y1  in  CW  overlay window y bounds, inclusive.
- err_clr  in  1  clears the sticky error flags.
- pixel_valid  out  1  count_x/count_y describe a valid active pixel.
- count_x  out  CW  pixel column, 0..H_ACTIVE-1.
- count_y  out  CW  pixel row, 0..V_ACTIVE-1.
- in_window  out  1  current pixel lies inside the overlay window.
- line_end  out  1  one-cycle pulse after the last pixel of a line.
- frame_end  out  1  one-cycle pulse after the last pixel of the last line.
- err_len  out  1  sticky flag: a line's pixel count differed from H_ACTIVE.
- err_lines  out  1  sticky flag: a frame's line count differed from V_ACTIVE at vsync.

Behaviour:
- Reset (async assert, sync-deassert at the system level): all outputs 0, internal x/y counters 0, edge registers 0.
- Latency: den sampled at cycle t gives registered outputs at t+1.
  - pixel_valid(t+1) = den(t).
  - count_x / count_y / in_window at t+1 describe that pixel.
  - When den=0, count_x/count_y hold their last values.
- X counter:
  - Increments on each den=1 cycle.
  - Counting past H_ACTIVE-1 while den stays high wraps to 0 and is treated as a line boundary (line_end pulse, y advance). This supports a continuously-high DE.
- Line end:
  - Falling edge of den (den(t-1)=1, den(t)=0) gives line_end=1 at t+1 and resets the x counter to 0.
  - The y counter increments, or wraps to 0 from V_ACTIVE-1.
  - If y wrapped, frame_end=1 in the same cycle as line_end.
  - A line cut short by the den fall still counts as a line.
- Vsync:
  - Falling edge of vs_n resets x and y to 0 and suppresses any pending line_end/frame_end for that cycle.
  - vs_n has priority over a simultaneous den edge.
  - A den=1 pixel in that same cycle is counted as x=0, y=0.
- in_window = pixel_valid-qualified (win_x0 <= x <= win_x1) AND (win_y0 <= y <= win_y1), unsigned compare.
  - x0 > x1 or y0 > y1 gives an empty window (always 0).
  - Window inputs are sampled every cycle; they are not latched per frame.
- Widths: all counters are CW bits, and all comparisons are done at CW bits.
- Reset asserted mid-line: counters return to 0 immediately; the first line after release is row 0.

Optional Feature:
Macro LCD_TRACK_ERR_EN.
- Defined:
  - err_len is set when a line ends (den fall or wrap) with pixel count != H_ACTIVE.
  - err_lines is set when a vs_n falling edge arrives with line count since the last vsync != V_ACTIVE. The first vsync after reset is excluded.
  - Both flags are sticky and are cleared by err_clr=1 for one cycle. If set and clear coincide, set wins.
- Undefined: err_len/err_lines are tied to 0, err_clr is ignored, and no checker logic is built.

Decomposition:
- Package lcd_timing_pkg holds:
  - default H_ACTIVE/V_ACTIVE/CW constants;
  - a typedef for the coordinate struct {x, y};
  - localparams for the common panels (800x480, 800x600).
- One natural sub-module, lcd_edge_det: a registered rise/fall detector, instantiated for den and vs_n.

Test Plan:
- Reset release, then 3 lines of 800 den=1 cycles separated by 10 idle cycles:
  - count_x runs 0..799 per line; count_y is 0, 1, 2;
  - line_end pulses 3 times, each one cycle after the den fall;
  - no errors.
- 480 full lines: frame_end pulses once, coincident with the 480th line_end; count_y returns to 0 on the next line.
- den held high for 1600 cycles: x wraps at 799 and one line_end is emitted; the second half reports y=1.
- vs_n falls during line 5, pixel 300: the next pixel is x=0, y=0; there is no line_end that cycle; err_lines is set (ERR_EN build).
- Window (100..199, 50..59): in_window is high for exactly 100 pixels in each of lines 50..59 (1000 total per frame). Window (200..100) gives 0 hits.
- ERR_EN build, line of 799 pixels: err_len=1 stays high until err_clr. Asserting err_clr together with a new short line leaves err_len=1.
